// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared bus widths, constants and the word-align helper for the fetch stage
package if_stage_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] INST_ADDR_ALIGN = 32'hFFFF_FFFC;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & INST_ADDR_ALIGN;
  endfunction
endpackage

// File: rtl/if_stage_pc_reg.sv
// if_stage_pc_reg: ROM chip-enable register and program counter next-state logic
//  ports: clk, rst (async active-low), i_stall_pc, i_branch/i_target (ID redirect),
//         i_flush/i_new_pc (exception redirect), o_ce (ROM enable), o_pc (fetch address)
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall_pc,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_new_pc,
  output logic              o_ce,
  output logic [ADDR_W-1:0] o_pc
);
  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  // flush beats stall so an exception redirect is never lost; pc+4 wraps naturally
  always_comb
    w_pc_next = i_flush    ? align(i_new_pc) :
                i_stall_pc ? r_pc :
                i_branch   ? align(i_target) :
                             r_pc + 32'd4;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ce <= CHIP_DISABLE;
      r_pc <= RESET_PC;
    end else begin
      r_ce <= CHIP_ENABLE;
      r_pc <= r_ce ? w_pc_next : RESET_PC;
    end
  assign o_ce = r_ce;
  assign o_pc = r_pc;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC, IF/ID pipeline register and saturating fetch counter
//  ports: clk, rst (async active-low), stall[5:0] (bit0 PC, bit1 IF, bit2 ID),
//         branch_flag_i/branch_target_i, flush_i/new_pc_i, rom_ce_o/rom_addr_o/rom_inst_i (ROM),
//         id_pc_o/id_inst_o/id_valid_o (IF/ID contents), fetch_cnt_o (instructions captured)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);
  logic              w_ce;
  logic [ADDR_W-1:0] w_pc;
  logic              w_capture;
  logic              w_hold;
  logic              w_unused;
  logic [ADDR_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_id_inst;
  logic              r_id_valid;
  logic [CNT_W-1:0]  r_cnt;
  if_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .i_stall_pc(stall[0]),
    .i_branch  (branch_flag_i),
    .i_target  (branch_target_i),
    .i_flush   (flush_i),
    .i_new_pc  (new_pc_i),
    .o_ce      (w_ce),
    .o_pc      (w_pc)
  );
  // a disabled ROM yields a bubble, so capture needs ce as well as no flush/IF stall
  assign w_capture = w_ce && !flush_i && !stall[1];
  assign w_hold    = !flush_i && stall[1] && stall[2];
  assign w_unused  = &{1'b0, stall[5:3]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_id_pc    <= '0;
      r_id_inst  <= ZERO_WORD;
      r_id_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (!w_hold) begin
        r_id_pc    <= w_capture ? w_pc : '0;
        r_id_inst  <= w_capture ? rom_inst_i : ZERO_WORD;
        r_id_valid <= w_capture;
      end
      if (w_capture && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  assign rom_ce_o    = w_ce;
  assign rom_addr_o  = w_pc;
  assign id_pc_o     = r_id_pc;
  assign id_inst_o   = r_id_inst;
  assign id_valid_o  = r_id_valid;
  assign fetch_cnt_o = r_cnt;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage against a behavioural fetch model
module tb_if_stage;
  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        vld;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;
  logic        clk = 0;
  logic        rst = 0;
  logic [5:0]  stall = '0;
  logic        br = 0, fl = 0;
  logic [31:0] tgt = '0, npc = '0;
  logic        ce16, ce4, vld16, vld4;
  logic [31:0] addr16, addr4, inst16, inst4, idpc16, idpc4, idinst16, idinst4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  exp_t        q[$];
  int          n_pass = 0, n_total = 0;
  logic        m_ce, m_vld;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  int          m_fetched;
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction
  assign inst16 = rom(addr16);
  assign inst4  = rom(addr4);
  if_stage u16 (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .flush_i(fl), .new_pc_i(npc), .rom_ce_o(ce16), .rom_addr_o(addr16), .rom_inst_i(inst16),
    .id_pc_o(idpc16), .id_inst_o(idinst16), .id_valid_o(vld16), .fetch_cnt_o(cnt16)
  );
  if_stage #(.CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .flush_i(fl), .new_pc_i(npc), .rom_ce_o(ce4), .rom_addr_o(addr4), .rom_inst_i(inst4),
    .id_pc_o(idpc4), .id_inst_o(idinst4), .id_valid_o(vld4), .fetch_cnt_o(cnt4)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
  endtask
  task automatic model_reset();
    m_ce = 0; m_pc = 0; m_id_pc = 0; m_id_inst = 0; m_vld = 0; m_fetched = 0;
  endtask
  task automatic check_reset_now();
    chk("rst_ce", {31'd0, ce16}, 0);
    chk("rst_addr", addr16, 0);
    chk("rst_idpc", idpc16, 0);
    chk("rst_inst", idinst16, 0);
    chk("rst_valid", {31'd0, vld16}, 0);
    chk("rst_cnt16", {16'd0, cnt16}, 0);
    chk("rst_cnt4", {28'd0, cnt4}, 0);
  endtask
  task automatic cycle(input logic [5:0] s, input logic b, input logic [31:0] t,
                       input logic f, input logic [31:0] n);
    logic [31:0] nxt;
    exp_t e;
    stall = s; br = b; tgt = t; fl = f; npc = n;
    nxt = !m_ce ? 32'd0 : f ? n & ~32'd3 : s[0] ? m_pc : b ? t & ~32'd3 : m_pc + 32'd4;
    if (f || (s[1] && !s[2]) || (!s[1] && !m_ce)) begin
      m_id_pc = 0; m_id_inst = 0; m_vld = 0;
    end else if (!s[1]) begin
      m_id_pc = m_pc; m_id_inst = rom(m_pc); m_vld = 1; m_fetched++;
    end
    m_ce = 1;
    m_pc = nxt;
    e.ce = m_ce; e.pc = m_pc; e.id_pc = m_id_pc; e.id_inst = m_id_inst; e.vld = m_vld;
    e.c16 = 16'(m_fetched);
    e.c4 = m_fetched > 15 ? 4'hF : 4'(m_fetched);
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(6'b0, 0, 0, 0, 0);
  endtask
  task automatic pulse_reset();
    #2 rst = 0;
    #1 check_reset_now();
    model_reset();
    #1 rst = 1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rom_ce", {31'd0, ce16}, {31'd0, e.ce});
        chk("rom_addr", addr16, e.pc);
        chk("id_pc", idpc16, e.id_pc);
        chk("id_inst", idinst16, e.id_inst);
        chk("id_valid", {31'd0, vld16}, {31'd0, e.vld});
        chk("fetch_cnt16", {16'd0, cnt16}, {16'd0, e.c16});
        chk("fetch_cnt4", {28'd0, cnt4}, {28'd0, e.c4});
      end
    end
  end
  initial begin : driver
    logic [5:0] s;
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_now();
    rst = 1;
    idle(5);
    cycle(6'b000011, 0, 0, 0, 0);
    cycle(6'b000011, 0, 0, 0, 0);
    idle(2);
    cycle(6'b000111, 0, 0, 0, 0);
    cycle(6'b000111, 0, 0, 0, 0);
    idle(2);
    cycle(6'b0, 1, 32'h103, 0, 0);
    idle(2);
    cycle(6'b000001, 1, 32'h2000, 1, 32'h182);
    idle(2);
    cycle(6'b0, 0, 0, 1, 32'hFFFF_FFF9);
    idle(3);
    idle(20);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pulse_reset();
      r = $urandom_range(0, 99);
      s = r < 70 ? 6'b000000 : r < 80 ? 6'b000011 : r < 88 ? 6'b000111 :
          r < 94 ? 6'b000001 : 6'($urandom);
      cycle(s, $urandom_range(0, 99) < 15, $urandom, $urandom_range(0, 99) < 6, $urandom);
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
